// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
// Issues one 32-bit DTIM access per lane for a decoded vle32/vlse32/vse32
// command. Loads collect their responses into a VLEN*32 write-back word.
// Stores slice the source vector into one word per element.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// CHECK | alignment check of the current element address
// REQ   | mem_req_valid high; request fields held until accepted
// WAIT  | one request outstanding; waiting for its response/acknowledge
// WB    | one-cycle wb_valid pulse with the assembled load vector
module vec_mem_sequencer #(
  parameter int VLEN       = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_store,
  input  logic                  cmd_strided,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [4:0]            cmd_vd,
  input  logic [VLEN*32-1:0]    cmd_store_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [31:0]           mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_vd,
  output logic [VLEN*32-1:0]    wb_data,
  output logic                  err_misaligned,
  output logic                  busy
);

  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [4:0]            vd_q, vd_d;
  logic                  is_store_q, is_store_d;
  logic [VLEN*32-1:0]    sdata_q, sdata_d;
  logic [VLEN*32-1:0]    lanes_q, lanes_d;

  logic addr_misaligned;
  assign addr_misaligned = (addr_q[1:0] != 2'b00);

  // Next-state and datapath updates; the address advances incrementally so
  // addr = base + i*stride wraps naturally modulo 2^ADDR_WIDTH.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    vd_d       = vd_q;
    is_store_d = is_store_q;
    sdata_d    = sdata_q;
    lanes_d    = lanes_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_CHECK;
          idx_d      = '0;
          addr_d     = cmd_base;
          stride_d   = cmd_strided ? cmd_stride : ADDR_WIDTH'(4);
          vd_d       = cmd_vd;
          is_store_d = cmd_is_store;
          sdata_d    = cmd_store_data;
        end
      end
      S_CHECK: begin
        state_d = addr_misaligned ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (!is_store_q) lanes_d[int'(idx_q)*32 +: 32] = mem_resp_rdata;
          if (idx_q == LAST_IDX) begin
            state_d = is_store_q ? S_IDLE : S_WB;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + stride_q;
            state_d = S_CHECK;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      stride_q   <= '0;
      vd_q       <= '0;
      is_store_q <= 1'b0;
      sdata_q    <= '0;
      lanes_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      vd_q       <= vd_d;
      is_store_q <= is_store_d;
      sdata_q    <= sdata_d;
      lanes_q    <= lanes_d;
    end
  end

  // Outputs decode directly from registered state, so request fields are
  // stable for as long as REQ is held by backpressure.
  always_comb begin
    cmd_ready      = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    mem_req_valid  = (state_q == S_REQ);
    mem_req_addr   = addr_q;
    mem_req_wen    = is_store_q;
    mem_req_wdata  = sdata_q[int'(idx_q)*32 +: 32];
    mem_req_wmask  = is_store_q ? 4'hF : 4'h0;
    wb_valid       = (state_q == S_WB);
    wb_vd          = vd_q;
    wb_data        = lanes_q;
    err_misaligned = (state_q == S_CHECK) && addr_misaligned;
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomized bench for vec_mem_sequencer with a transaction-level model:
// expected addresses are base + i*stride, aborting at the first misaligned
// element; the loaded vector is whatever the bench's responder returned.
module tb_vec_mem_sequencer;

  localparam int VLEN = 2;
  localparam int AW   = 32;
  localparam int W    = VLEN * 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_is_store = 1'b0;
  logic          cmd_strided = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_stride = '0;
  logic [4:0]    cmd_vd = '0;
  logic [W-1:0]  cmd_store_data = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [31:0]   mem_req_wdata;
  logic [3:0]    mem_req_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [31:0]   mem_resp_rdata = '0;
  logic          wb_valid;
  logic [4:0]    wb_vd;
  logic [W-1:0]  wb_data;
  logic          err_misaligned;
  logic          busy;

  vec_mem_sequencer #(.VLEN(VLEN), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_store(cmd_is_store), .cmd_strided(cmd_strided),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vd(cmd_vd),
    .cmd_store_data(cmd_store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .wb_data(wb_data),
    .err_misaligned(err_misaligned), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [W-1:0] last_wb  = '0;
  int           last_lat = 0;
  logic [31:0]  fix_rd[VLEN];
  bit           use_fix  = 1'b0;

  task automatic run_cmd(input bit st, input bit strd, input logic [31:0] base,
                         input logic [31:0] stride, input logic [4:0] vd,
                         input logic [W-1:0] sdata, input bit fast, input int bp0);
    logic [31:0] e_addr[$];
    logic [31:0] lanes[VLEN];
    logic [31:0] eff, a, rd, h_addr, h_wdata;
    logic [W-1:0] ev;
    bit   exp_err, pend, stall, rdy, done;
    int   exp_n, cyc, req_n, resp_n, wb_cnt, err_cnt, dly, bp;

    eff = strd ? stride : 32'd4;
    exp_err = 1'b0;
    for (int i = 0; i < VLEN; i++) begin
      a = base + 32'(i) * eff;
      if (a[1:0] != 2'b00) begin
        exp_err = 1'b1;
        break;
      end
      e_addr.push_back(a);
    end
    exp_n = e_addr.size();
    for (int i = 0; i < VLEN; i++) lanes[i] = '0;

    @(negedge clock);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid      = 1'b1;
    cmd_is_store   = st;
    cmd_strided    = strd;
    cmd_base       = base;
    cmd_stride     = strd ? stride : $urandom;
    cmd_vd         = vd;
    cmd_store_data = sdata;

    cyc = 0; req_n = 0; resp_n = 0; wb_cnt = 0; err_cnt = 0;
    pend = 1'b0; dly = 0; stall = 1'b0; bp = bp0; done = 1'b0;
    h_addr = '0; h_wdata = '0;
    while (!done) begin
      @(negedge clock);
      cmd_valid      = 1'b0;
      mem_resp_valid = 1'b0;
      cyc++;
      if (cyc == 1) chk("cmd_ready_drop", cmd_ready, 1'b0);
      if (wb_valid) begin
        wb_cnt++;
        for (int i = 0; i < VLEN; i++) ev[i*32 +: 32] = lanes[i];
        chk("wb_data", wb_data, ev);
        chk("wb_vd", wb_vd, vd);
        last_wb  = wb_data;
        last_lat = cyc;
        if (fast && bp0 == 0) chk("wb_latency", cyc, 3*VLEN + 1);
      end
      if (err_misaligned) err_cnt++;
      if (stall) begin
        chk("bp_valid_held", mem_req_valid, 1'b1);
        chk("bp_addr_held", mem_req_addr, h_addr);
        chk("bp_wdata_held", mem_req_wdata, h_wdata);
      end
      if (cyc > 1 && cmd_ready) begin
        done = 1'b1;
      end else if (cyc > 200) begin
        chk("timeout_cmd_ready", cmd_ready, 1'b1);
        done = 1'b1;
      end else begin
        // responder: exactly one response per accepted request, plus stray pulses when idle
        if (pend) begin
          if (dly == 0) begin
            rd = use_fix ? fix_rd[resp_n] : $urandom;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rd;
            if (!st) lanes[resp_n] = rd;
            resp_n++;
            pend = 1'b0;
          end else begin
            dly--;
          end
        end else if (!fast && $urandom_range(0, 3) == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = $urandom;
        end
        if (mem_req_valid) begin
          if (req_n < exp_n) begin
            chk("req_addr", mem_req_addr, e_addr[req_n]);
            chk("req_wen", mem_req_wen, st);
            chk("req_wmask", mem_req_wmask, st ? 4'hF : 4'h0);
            if (st) chk("req_wdata", mem_req_wdata, sdata[req_n*32 +: 32]);
          end else begin
            chk("extra_req", req_n, exp_n);
          end
          if (req_n == 0 && bp > 0) begin
            rdy = 1'b0;
            bp--;
          end else begin
            rdy = fast ? 1'b1 : 1'($urandom_range(0, 1));
          end
          mem_req_ready = rdy;
          stall   = !rdy;
          h_addr  = mem_req_addr;
          h_wdata = mem_req_wdata;
          if (rdy) begin
            req_n++;
            pend = 1'b1;
            dly  = fast ? 0 : $urandom_range(0, 2);
          end
        end else begin
          mem_req_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
          stall = 1'b0;
        end
      end
    end
    chk("req_count", req_n, exp_n);
    chk("err_count", err_cnt, exp_err);
    chk("wb_count", wb_cnt, (!st && !exp_err) ? 1 : 0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({pfx, "_busy"}, busy, 1'b0);
    chk({pfx, "_req_valid"}, mem_req_valid, 1'b0);
    chk({pfx, "_wb_valid"}, wb_valid, 1'b0);
    chk({pfx, "_err"}, err_misaligned, 1'b0);
    chk({pfx, "_wb_data"}, wb_data, '0);
    chk({pfx, "_wb_vd"}, wb_vd, 5'd0);
  endtask

  task automatic reset_in_wait();
    int n;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_strided = 1'b0;
    cmd_base = 32'h0800_0200; cmd_vd = 5'd9; mem_req_ready = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("rst_req_seen", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    chk("rst_busy_in_wait", busy, 1'b1);
    chk("rst_no_req_in_wait", mem_req_valid, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("rst_during");
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("rst_after");
  endtask

  initial begin
    logic [31:0] b, s;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    // unit-stride load with fixed response data
    fix_rd[0] = 32'hDEAD_BEEF;
    fix_rd[1] = 32'h1234_5678;
    use_fix = 1'b1;
    run_cmd(1'b0, 1'b0, 32'h0800_0100, 32'h0, 5'd2, '0, 1'b1, 0);
    chk("unit_load_wb_data", last_wb, 64'h1234_5678_DEAD_BEEF);
    chk("unit_load_latency", last_lat, 7);
    use_fix = 1'b0;

    run_cmd(1'b0, 1'b1, 32'h0800_0100, 32'h10, 5'd3, '0, 1'b0, 0);
    run_cmd(1'b1, 1'b0, 32'h0800_0100, 32'h0, 5'd4, 64'h1234_5671_1234_5670, 1'b1, 0);
    run_cmd(1'b0, 1'b0, 32'h0800_0100, 32'h0, 5'd5, '0, 1'b1, 3);
    run_cmd(1'b1, 1'b0, 32'h0800_0300, 32'h0, 5'd6, 64'hAAAA_5555_0F0F_F0F0, 1'b1, 3);
    run_cmd(1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 5'd7, '0, 1'b0, 0);
    run_cmd(1'b0, 1'b0, 32'h0800_0102, 32'h0, 5'd8, '0, 1'b1, 0);
    run_cmd(1'b0, 1'b1, 32'h0800_0100, 32'h2, 5'd10, '0, 1'b1, 0);
    run_cmd(1'b1, 1'b1, 32'h0800_0100, 32'h6, 5'd11, 64'h1111_2222_3333_4444, 1'b0, 0);
    reset_in_wait();

    for (int k = 0; k < 40; k++) begin
      b = $urandom;
      if ($urandom_range(0, 4) != 0) b[1:0] = 2'b00;
      s = ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
      if ($urandom_range(0, 4) != 0) s[1:0] = 2'b00;
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, s,
              5'($urandom_range(0, 31)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
